sram_config_loader: RTL and testbench

Parallel-to-serial configuration loader that sits directly upstream of the SRAM tile's configuration shift chain. It accepts one (address, data) write record per valid/ready handshake and shifts it MSB-first into the tile's `shift_in`. It then pulses `config_set` so the tile's configurator writes the word into the unit SRAM. It also holds the tile's `sram_conf` mode, counts committed frames, and flags end-of-load.

---
 rtl/sram_config_loader.sv | 157 +++++++++++++++
 tb/tb_sram_config_loader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_config_loader.sv
// Parallel-to-serial loader feeding an SRAM tile's configuration shift chain.
// Optional echo check of the tile's shift_out is built when SRAM_CFG_ECHO_CHECK_EN is defined.
module sram_config_loader #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [ADDR_BITS-1:0] s_addr,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic [1:0]           s_mode,
    input  logic                 s_last,
    output logic                 shift_in,
    output logic                 shift_enable,
    output logic                 config_set,
    output logic [1:0]           sram_conf,
    input  logic                 chain_in,
    output logic [ADDR_BITS:0]   frame_cnt,
    output logic                 done,
    output logic                 err
);
    localparam int FRAME_BITS = ADDR_BITS + DATA_BITS;
    localparam int CW         = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [1:0]            mode_q, mode_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;
    logic [ADDR_BITS:0]    fcnt_q, fcnt_d;
    logic                  ready_q, ready_d;
    logic                  sen_q, sen_d;
    logic                  sin_q, sin_d;
    logic                  cset_q, cset_d;
    logic [FRAME_BITS-1:0] frame_in;

    assign frame_in = {s_addr, s_data};

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        mode_d  = mode_q;
        last_d  = last_q;
        done_d  = done_q;
        fcnt_d  = fcnt_q;
        ready_d = 1'b0;
        sen_d   = 1'b0;
        sin_d   = 1'b0;
        cset_d  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (s_valid && ready_q) begin
                    frame_d = frame_in;
                    mode_d  = s_mode;
                    last_d  = s_last;
                    done_d  = 1'b0;
                    cnt_d   = CW'(FRAME_BITS - 1);
                    sen_d   = 1'b1;
                    sin_d   = frame_in[FRAME_BITS-1];
                    ready_d = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    cset_d  = 1'b1;
                    fcnt_d  = fcnt_q + 1'b1;
                    done_d  = done_q | last_q;
                    state_d = COMMIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    sen_d = 1'b1;
                    sin_d = frame_q[cnt_q - 1'b1];
                end
            end
            COMMIT: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            frame_q <= '0;
            mode_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            fcnt_q  <= '0;
            ready_q <= 1'b0;
            sen_q   <= 1'b0;
            sin_q   <= 1'b0;
            cset_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
            done_q  <= done_d;
            fcnt_q  <= fcnt_d;
            ready_q <= ready_d;
            sen_q   <= sen_d;
            sin_q   <= sin_d;
            cset_q  <= cset_d;
        end
    end

    assign s_ready      = ready_q;
    assign shift_in     = sin_q;
    assign shift_enable = sen_q;
    assign config_set   = cset_q;
    assign sram_conf    = mode_q;
    assign frame_cnt    = fcnt_q;
    assign done         = done_q;

`ifdef SRAM_CFG_ECHO_CHECK_EN
    // While shifting bit cnt_q of the new frame, the tile's MSB should be the
    // same bit position of the frame committed before it.
    logic [FRAME_BITS-1:0] prev_q;
    logic                  prev_vld_q;
    logic                  err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == SHIFT && prev_vld_q && (chain_in != prev_q[cnt_q]))
                err_q <= 1'b1;
            if (state_q == COMMIT) begin
                prev_q     <= frame_q;
                prev_vld_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    logic unused_chain_in;
    assign unused_chain_in = chain_in;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_config_loader.sv
// Randomized self-checking bench for sram_config_loader with a behavioural tile chain.
module tb_sram_config_loader;
    localparam int AB = 10;
    localparam int DB = 32;
    localparam int FB = AB + DB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [AB-1:0] s_addr = '0;
    logic [DB-1:0] s_data = '0;
    logic [1:0]    s_mode = '0;
    logic          s_last = 1'b0;
    logic          shift_in, shift_enable, config_set;
    logic [1:0]    sram_conf;
    logic          chain_in;
    logic [AB:0]   frame_cnt;
    logic          done, err;

    sram_config_loader #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_addr(s_addr), .s_data(s_data), .s_mode(s_mode), .s_last(s_last),
        .shift_in(shift_in), .shift_enable(shift_enable), .config_set(config_set),
        .sram_conf(sram_conf), .chain_in(chain_in), .frame_cnt(frame_cnt),
        .done(done), .err(err)
    );

    // Tile chain model: shifts in on shift_enable, presents its MSB on shift_out.
    logic [FB-1:0] tile_q = '0;
    logic          flip = 1'b0;
    always @(posedge clk) if (shift_enable) tile_q <= {tile_q[FB-2:0], shift_in};
    assign chain_in = tile_q[FB-1] ^ flip;

    // Small instance used for the frame counter wrap (4-bit counter, 10-cycle frames).
    logic       w_valid = 1'b0, w_ready, w_last = 1'b0;
    logic [2:0] w_addr = 3'd5;
    logic [4:0] w_data = 5'd19;
    logic [1:0] w_mode = 2'd1;
    logic       w_sin, w_sen, w_cset, w_chain = 1'b0, w_done, w_err;
    logic [1:0] w_conf;
    logic [3:0] w_fcnt;

    sram_config_loader #(.ADDR_BITS(3), .DATA_BITS(5)) dut_w (
        .clk(clk), .rst(rst), .s_valid(w_valid), .s_ready(w_ready),
        .s_addr(w_addr), .s_data(w_data), .s_mode(w_mode), .s_last(w_last),
        .shift_in(w_sin), .shift_enable(w_sen), .config_set(w_cset),
        .sram_conf(w_conf), .chain_in(w_chain), .frame_cnt(w_fcnt),
        .done(w_done), .err(w_err)
    );

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    bit exp_done = 0, exp_err = 0, prev_vld = 0;

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        s_valid = 1'b0;
        w_valid = 1'b0;
        flip = 1'b0;
        #1;
        checks++;
        if ({shift_in, shift_enable, config_set, sram_conf, frame_cnt, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0",
                     {shift_in, shift_enable, config_set, sram_conf, frame_cnt, done, err});
        end
        @(negedge clk);
        rst = 1'b1;
        exp_cnt = 0; exp_done = 0; exp_err = 0; prev_vld = 0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b exp 1", s_ready);
        end
    endtask

    // Offers one record, waits for the handshake and checks the whole frame period.
    task automatic send_rec(input logic [AB-1:0] a, input logic [DB-1:0] d,
                            input logic [1:0] m, input logic l, input int flip_idx,
                            input bit noise, input bit keep_valid, output int acc_cyc);
        logic [FB-1:0] fr;
        int waited;
        fr = {a, d};
        s_addr = a; s_data = d; s_mode = m; s_last = l; s_valid = 1'b1;
        waited = 0;
        while (s_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        acc_cyc = -1;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout got s_ready=%b exp 1", s_ready);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        acc_cyc = int'($time / 10);
        exp_done = 0;
        for (int i = 0; i < FB; i++) begin
            @(negedge clk);
            checks++;
            if ({shift_enable, config_set, s_ready} !== 3'b100) begin
                errors++;
                $display("FAIL shift_ctl i=%0d got en/set/rdy=%b exp 100", i,
                         {shift_enable, config_set, s_ready});
            end
            checks++;
            if (shift_in !== fr[FB-1-i]) begin
                errors++;
                $display("FAIL shift_bit i=%0d got %b exp %b", i, shift_in, fr[FB-1-i]);
            end
            if (i == 0) begin
                checks++;
                if ({done, sram_conf} !== {1'b0, m}) begin
                    errors++;
                    $display("FAIL accept_state got done/conf=%b exp %b", {done, sram_conf}, {1'b0, m});
                end
            end
            flip = (i == flip_idx);
            if (noise) begin
                s_valid = 1'($urandom);
                s_addr = AB'($urandom);
                s_data = $urandom;
                s_mode = 2'($urandom);
            end else if (!keep_valid) begin
                s_valid = 1'b0;
            end
        end
        exp_cnt = (exp_cnt + 1) % (1 << (AB + 1));
        if (l) exp_done = 1;
`ifdef SRAM_CFG_ECHO_CHECK_EN
        if (prev_vld && flip_idx >= 0 && flip_idx < FB) exp_err = 1;
        prev_vld = 1;
`endif
        @(negedge clk);
        flip = 1'b0;
        checks++;
        if ({config_set, shift_enable} !== 2'b10) begin
            errors++;
            $display("FAIL commit_ctl got set/en=%b exp 10", {config_set, shift_enable});
        end
        checks++;
        if (frame_cnt !== exp_cnt[AB:0]) begin
            errors++;
            $display("FAIL frame_cnt got %0d exp %0d", frame_cnt, exp_cnt);
        end
        checks++;
        if ({done, sram_conf, err} !== {exp_done, m, exp_err}) begin
            errors++;
            $display("FAIL commit_flags got done/conf/err=%b exp %b",
                     {done, sram_conf, err}, {exp_done, m, exp_err});
        end
        if (!keep_valid) s_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_single();
        int t;
        send_rec(10'h155, 32'hDEADBEEF, 2'd2, 1'b1, -1, 0, 0, t);
        @(negedge clk);
        checks++;
        if ({s_ready, config_set, shift_enable} !== 3'b100) begin
            errors++;
            $display("FAIL post_commit got rdy/set/en=%b exp 100", {s_ready, config_set, shift_enable});
        end
    endtask

    task automatic test_back_to_back();
        int t[3];
        apply_reset();
        for (int r = 0; r < 3; r++)
            send_rec(AB'($urandom), $urandom, 2'($urandom), r == 2, -1, 0, 1, t[r]);
        s_valid = 1'b0;
        for (int r = 1; r < 3; r++) begin
            checks++;
            if (t[r] - t[r-1] !== FB + 2) begin
                errors++;
                $display("FAIL b2b_spacing r=%0d got %0d exp %0d", r, t[r] - t[r-1], FB + 2);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_noise();
        int t;
        for (int r = 0; r < 3; r++)
            send_rec(AB'($urandom), $urandom, 2'($urandom), 1'($urandom), -1, 1, 0, t);
        @(negedge clk);
        checks++;
        if ({s_ready, shift_enable} !== 2'b10) begin
            errors++;
            $display("FAIL noise_idle got rdy/en=%b exp 10", {s_ready, shift_enable});
        end
    endtask

    task automatic test_reset_mid();
        int waited, t;
        bit seen_set;
        s_addr = AB'($urandom); s_data = $urandom; s_mode = 2'd3; s_last = 1'b1;
        s_valid = 1'b1;
        waited = 0;
        while (s_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (19) @(negedge clk);
        checks++;
        if (shift_enable !== 1'b1) begin
            errors++;
            $display("FAIL mid_shift_active got %b exp 1", shift_enable);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({s_ready, shift_in, shift_enable, config_set, sram_conf, frame_cnt, done, err} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b exp 0",
                     {s_ready, shift_in, shift_enable, config_set, sram_conf, frame_cnt, done, err});
        end
        seen_set = 0;
        repeat (3) begin
            @(negedge clk);
            if (config_set) seen_set = 1;
        end
        rst = 1'b1;
        exp_cnt = 0; exp_done = 0; exp_err = 0; prev_vld = 0;
        repeat (30) begin
            @(negedge clk);
            if (config_set || shift_enable) seen_set = 1;
        end
        checks++;
        if (seen_set !== 1'b0) begin
            errors++;
            $display("FAIL abandoned_commit got activity=%b exp 0", seen_set);
        end
        send_rec(AB'($urandom), $urandom, 2'd1, 1'b0, -1, 0, 0, t);
    endtask

    task automatic test_echo();
        int t;
        apply_reset();
        send_rec(AB'($urandom), $urandom, 2'd0, 1'b0, 7, 0, 0, t);
        send_rec(AB'($urandom), $urandom, 2'd1, 1'b0, -1, 0, 0, t);
        send_rec(AB'($urandom), $urandom, 2'd2, 1'b0, int'($urandom_range(FB - 1, 0)), 0, 0, t);
        send_rec(AB'($urandom), $urandom, 2'd3, 1'b1, -1, 0, 0, t);
    endtask

    task automatic test_wrap();
        int n, budget;
        n = 0;
        budget = 0;
        w_valid = 1'b1;
        while (n < 16 && budget < 300) begin
            @(negedge clk);
            budget++;
            if (w_cset === 1'b1) begin
                n++;
                checks++;
                if (w_fcnt !== 4'(n % 16)) begin
                    errors++;
                    $display("FAIL wrap_cnt n=%0d got %0d exp %0d", n, w_fcnt, n % 16);
                end
            end
        end
        w_valid = 1'b0;
        checks++;
        if (n != 16 || w_fcnt !== 4'd0) begin
            errors++;
            $display("FAIL wrap_final got commits=%0d cnt=%0d exp 16 and 0", n, w_fcnt);
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_single();
        test_back_to_back();
        test_noise();
        test_reset_mid();
        test_echo();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
